// File: rtl/arm_pipe_pkg.sv
// rtl/arm_pipe_pkg.sv - shared state encodings and defaults for the ARM pipeline control logic
//
// Purpose : stall/flush sequencer FSM state encoding and default counter width.
// Contents: ST_RUN, ST_MEM_WAIT, ST_FAULT state constants; CNT_W_DEFAULT.
package arm_pipe_pkg;

    localparam logic [1:0] ST_RUN      = 2'd0;
    localparam logic [1:0] ST_MEM_WAIT = 2'd1;
    localparam logic [1:0] ST_FAULT    = 2'd2;

    localparam int CNT_W_DEFAULT = 16;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with synchronous clear
//
// Purpose : counts cycles with inc=1, holds at all-ones, clr wins over inc.
// Ports   : clk, rst_n (async active-low), inc, clr, count[W-1:0].
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != {W{1'b1}})) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pipeline_stall_controller.sv
// rtl/pipeline_stall_controller.sv - stall/flush sequencer for the 5-stage ARM pipeline
//
// Purpose : merges hazard, branch-taken and SRAM handshake into per-stage
//           freeze/flush controls, defers branch flushes across memory stalls,
//           detects hung memory accesses and keeps stall/flush counters.
// Ports   : clk, rst (async active-low), hazard, branch_taken, mem_req,
//           mem_ready, cnt_clr in; freeze_if/id/exe/mem, flush_if_id,
//           flush_id_exe, mem_timeout, state[1:0], stall_cycles, flush_count out.
module pipeline_stall_controller
    import arm_pipe_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEFAULT,
    parameter int MEM_TIMEOUT = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hazard,
    input  logic             branch_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    input  logic             cnt_clr,
    output logic             freeze_if,
    output logic             freeze_id,
    output logic             freeze_exe,
    output logic             freeze_mem,
    output logic             flush_if_id,
    output logic             flush_id_exe,
    output logic             mem_timeout,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    logic [1:0]        state_q, state_d;
    logic              br_pend_q, br_pend_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;

    logic mem_stall;
    logic hold_all;
    logic br_eff;

    assign mem_stall = ((state_q == ST_RUN) && mem_req && !mem_ready) ||
                       ((state_q == ST_MEM_WAIT) && !mem_ready);
    assign hold_all  = (state_q == ST_FAULT) || mem_stall;
    assign br_eff    = branch_taken || br_pend_q;

    // Mealy control outputs. Everything is forced low while reset is held so
    // the pipeline registers see no spurious freeze/flush during reset.
    always_comb begin
        freeze_if    = 1'b0;
        freeze_id    = 1'b0;
        freeze_exe   = 1'b0;
        freeze_mem   = 1'b0;
        flush_if_id  = 1'b0;
        flush_id_exe = 1'b0;
        if (rst) begin
            if (hold_all) begin
                freeze_if  = 1'b1;
                freeze_id  = 1'b1;
                freeze_exe = 1'b1;
                freeze_mem = 1'b1;
            end else if (br_eff) begin
                // Branch beats hazard: the hazarding instruction is flushed anyway.
                flush_if_id  = 1'b1;
                flush_id_exe = 1'b1;
            end else if (hazard) begin
                freeze_if    = 1'b1;
                flush_id_exe = 1'b1;
            end
        end
    end

    // A branch resolved during a full stall is remembered and flushed on the
    // first cycle the pipeline moves again; further pulses merge into it.
    always_comb begin
        br_pend_d = br_pend_q;
        if (hold_all) begin
            br_pend_d = br_pend_q | branch_taken;
        end else if (br_eff) begin
            br_pend_d = 1'b0;
        end
    end

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = '0;
        case (state_q)
            ST_RUN: begin
                if (mem_req && !mem_ready) begin
                    state_d = ST_MEM_WAIT;
                end
            end
            ST_MEM_WAIT: begin
                if (mem_ready) begin
                    state_d = ST_RUN;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    state_d = ST_FAULT;
                end else begin
                    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                end
            end
            ST_FAULT: begin
                state_d = ST_FAULT;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_RUN;
            br_pend_q  <= 1'b0;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            br_pend_q  <= br_pend_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    assign state       = state_q;
    assign mem_timeout = (state_q == ST_FAULT);

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst),
        .inc   (freeze_if),
        .clr   (cnt_clr),
        .count (stall_cycles)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst),
        .inc   (flush_if_id),
        .clr   (cnt_clr),
        .count (flush_count)
    );

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// tb/tb_pipeline_stall_controller.sv - directed self-checking bench for pipeline_stall_controller
module tb_pipeline_stall_controller;

    localparam int CNT_W = 3;
    localparam int MEM_TIMEOUT = 4;

    localparam logic [5:0] CTL_NONE  = 6'b000000;
    localparam logic [5:0] CTL_STALL = 6'b111100;
    localparam logic [5:0] CTL_HAZ   = 6'b100001;
    localparam logic [5:0] CTL_FLUSH = 6'b000011;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, hazard, branch_taken, mem_req, mem_ready, cnt_clr;
    logic freeze_if, freeze_id, freeze_exe, freeze_mem, flush_if_id, flush_id_exe;
    logic mem_timeout;
    logic [1:0] state;
    logic [CNT_W-1:0] stall_cycles, flush_count;
    logic [5:0] ctl;

    assign ctl = {freeze_if, freeze_id, freeze_exe, freeze_mem, flush_if_id, flush_id_exe};

    int n_cmp = 0;
    int n_err = 0;

    pipeline_stall_controller #(.CNT_W(CNT_W), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
        .clk          (clk),
        .rst          (rst),
        .hazard       (hazard),
        .branch_taken (branch_taken),
        .mem_req      (mem_req),
        .mem_ready    (mem_ready),
        .cnt_clr      (cnt_clr),
        .freeze_if    (freeze_if),
        .freeze_id    (freeze_id),
        .freeze_exe   (freeze_exe),
        .freeze_mem   (freeze_mem),
        .flush_if_id  (flush_if_id),
        .flush_id_exe (flush_id_exe),
        .mem_timeout  (mem_timeout),
        .state        (state),
        .stall_cycles (stall_cycles),
        .flush_count  (flush_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Apply inputs just after the falling edge, sample 1 ns later.
    task automatic cyc(input logic h, input logic b, input logic mq, input logic mr, input logic c);
        @(negedge clk);
        hazard       = h;
        branch_taken = b;
        mem_req      = mq;
        mem_ready    = mr;
        cnt_clr      = c;
        #1;
    endtask

    initial begin
        rst = 1'b0;
        hazard = 1'b1; branch_taken = 1'b1; mem_req = 1'b1; mem_ready = 1'b0; cnt_clr = 1'b0;
        #12;
        chk("rst_ctl",     32'(ctl), 32'(CTL_NONE));
        chk("rst_state",   32'(state), 32'd0);
        chk("rst_timeout", 32'(mem_timeout), 32'd0);
        chk("rst_stall",   32'(stall_cycles), 32'd0);
        chk("rst_flush",   32'(flush_count), 32'd0);

        cyc(0, 0, 0, 0, 0);
        rst = 1'b1;
        cyc(0, 0, 0, 0, 0);
        chk("idle_ctl", 32'(ctl), 32'(CTL_NONE));

        // Hazard for two cycles
        cyc(1, 0, 0, 0, 0);
        chk("haz1_ctl", 32'(ctl), 32'(CTL_HAZ));
        cyc(1, 0, 0, 0, 0);
        chk("haz2_ctl", 32'(ctl), 32'(CTL_HAZ));
        cyc(0, 0, 0, 0, 0);
        chk("haz_end_ctl", 32'(ctl), 32'(CTL_NONE));
        chk("haz_stall_cnt", 32'(stall_cycles), 32'd2);
        chk("haz_flush_cnt", 32'(flush_count), 32'd0);
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0);
        chk("clr_stall_cnt", 32'(stall_cycles), 32'd0);

        // Three-cycle memory stall then release
        cyc(0, 0, 1, 0, 0);
        chk("ms_c1_ctl", 32'(ctl), 32'(CTL_STALL));
        chk("ms_c1_state", 32'(state), 32'd0);
        cyc(0, 0, 1, 0, 0);
        chk("ms_c2_ctl", 32'(ctl), 32'(CTL_STALL));
        chk("ms_c2_state", 32'(state), 32'd1);
        cyc(0, 0, 1, 0, 0);
        chk("ms_c3_ctl", 32'(ctl), 32'(CTL_STALL));
        chk("ms_c3_state", 32'(state), 32'd1);
        cyc(0, 0, 1, 1, 0);
        chk("ms_rel_ctl", 32'(ctl), 32'(CTL_NONE));
        chk("ms_rel_state", 32'(state), 32'd1);
        cyc(0, 0, 0, 0, 0);
        chk("ms_after_state", 32'(state), 32'd0);
        chk("ms_stall_cnt", 32'(stall_cycles), 32'd3);
        cyc(0, 0, 0, 0, 1);

        // Branch during a four-cycle stall; release at the last wait count
        cyc(0, 0, 1, 0, 0);
        chk("bs_c1_ctl", 32'(ctl), 32'(CTL_STALL));
        cyc(0, 1, 1, 0, 0);
        chk("bs_c2_ctl", 32'(ctl), 32'(CTL_STALL));
        cyc(0, 0, 1, 0, 0);
        chk("bs_c3_ctl", 32'(ctl), 32'(CTL_STALL));
        cyc(0, 0, 1, 0, 0);
        chk("bs_c4_ctl", 32'(ctl), 32'(CTL_STALL));
        cyc(0, 0, 1, 1, 0);
        chk("bs_rel_ctl", 32'(ctl), 32'(CTL_FLUSH));
        chk("bs_rel_state", 32'(state), 32'd1);
        cyc(0, 0, 0, 0, 0);
        chk("bs_after_ctl", 32'(ctl), 32'(CTL_NONE));
        chk("bs_after_state", 32'(state), 32'd0);
        chk("bs_flush_cnt", 32'(flush_count), 32'd1);
        chk("bs_stall_cnt", 32'(stall_cycles), 32'd4);

        // Hazard and branch together in RUN
        cyc(1, 1, 0, 0, 0);
        chk("hb_ctl", 32'(ctl), 32'(CTL_FLUSH));
        cyc(0, 0, 0, 0, 0);
        chk("hb_after_ctl", 32'(ctl), 32'(CTL_NONE));
        chk("hb_flush_cnt", 32'(flush_count), 32'd2);

        // Request completing in the same cycle: no stall
        cyc(0, 0, 1, 1, 0);
        chk("fast_mem_ctl", 32'(ctl), 32'(CTL_NONE));
        cyc(0, 0, 0, 0, 0);
        chk("fast_mem_state", 32'(state), 32'd0);

        // Stall counter saturation, then clear together with hazard
        cyc(0, 0, 0, 0, 1);
        for (int i = 0; i < 10; i++) begin
            cyc(1, 0, 0, 0, 0);
        end
        cyc(0, 0, 0, 0, 0);
        chk("sat_stall_cnt", 32'(stall_cycles), 32'd7);
        cyc(1, 0, 0, 0, 1);
        chk("clrhaz_ctl", 32'(ctl), 32'(CTL_HAZ));
        cyc(0, 0, 0, 0, 0);
        chk("clrhaz_stall_cnt", 32'(stall_cycles), 32'd0);
        chk("clrhaz_flush_cnt", 32'(flush_count), 32'd0);

        // Hung access: one RUN stall cycle plus four MEM_WAIT cycles, then FAULT
        cyc(0, 0, 1, 0, 0);
        chk("to_c1_state", 32'(state), 32'd0);
        for (int i = 0; i < 4; i++) begin
            cyc(0, 0, 1, 0, 0);
            chk("to_wait_state", 32'(state), 32'd1);
            chk("to_wait_timeout", 32'(mem_timeout), 32'd0);
        end
        cyc(0, 0, 1, 0, 0);
        chk("to_fault_state", 32'(state), 32'd2);
        chk("to_fault_flag", 32'(mem_timeout), 32'd1);
        chk("to_fault_ctl", 32'(ctl), 32'(CTL_STALL));
        cyc(1, 1, 0, 1, 0);
        chk("to_persist_state", 32'(state), 32'd2);
        chk("to_persist_ctl", 32'(ctl), 32'(CTL_STALL));
        cyc(0, 0, 0, 1, 0);
        chk("to_persist2_flag", 32'(mem_timeout), 32'd1);
        chk("to_stall_cnt", 32'(stall_cycles), 32'd7);

        // Asynchronous reset mid-cycle, away from any edge
        #1;
        rst = 1'b0;
        #1;
        chk("arst_state", 32'(state), 32'd0);
        chk("arst_timeout", 32'(mem_timeout), 32'd0);
        chk("arst_ctl", 32'(ctl), 32'(CTL_NONE));
        chk("arst_stall", 32'(stall_cycles), 32'd0);
        chk("arst_flush", 32'(flush_count), 32'd0);
        cyc(0, 0, 0, 0, 0);
        rst = 1'b1;
        cyc(0, 0, 0, 0, 0);
        chk("post_rst_ctl", 32'(ctl), 32'(CTL_NONE));
        cyc(0, 0, 0, 0, 0);
        chk("post_rst_flush", 32'(flush_count), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pipeline_stall_controller.md
# pipeline_stall_controller

Central stall/flush sequencer for the 5-stage ARM pipeline. Combines the hazard-unit `hazard` flag, the EXE-stage branch-taken pulse and the SRAM handshake (`mem_req`/`mem_ready`) into per-stage freeze and flush controls. It holds a branch flush that arrives during a memory stall until the pipeline releases, and detects a hung memory access. It also keeps saturating stall and flush performance counters.

## Interface
Parameters:
- `CNT_W`, 16, width of each performance counter
- `MEM_TIMEOUT`, 1024, number of consecutive MEM_WAIT cycles that causes a fault (≥2)

Ports:
- `clk`  in  1  sole clock, rising edge
- `rst`  in  1  asynchronous, active-low reset
- `hazard`  in  1  RAW hazard from hazard detection unit (ID stage)
- `branch_taken`  in  1  one-cycle pulse from EXE branch resolution
- `mem_req`  in  1  MEM stage holds a load/store
- `mem_ready`  in  1  SRAM controller completes the access this cycle
- `cnt_clr`  in  1  synchronous clear of both counters
- `freeze_if`  out  1  hold PC and IF/ID register
- `freeze_id`  out  1  hold ID/EXE register
- `freeze_exe`  out  1  hold EXE/MEM register
- `freeze_mem`  out  1  hold MEM/WB register
- `flush_if_id`  out  1  clear IF/ID on next edge
- `flush_id_exe`  out  1  load bubble into ID/EXE on next edge
- `mem_timeout`  out  1  sticky fault flag
- `state`  out  2  current FSM state
- `stall_cycles`  out  CNT_W  cycles with `freeze_if`=1, saturating
- `flush_count`  out  CNT_W  cycles with `flush_if_id`=1, saturating

## Operation
- FSM states: RUN(0), MEM_WAIT(1), FAULT(2). Encoding 3 is unreachable and recovers to RUN.
- `mem_stall` = (state==RUN & mem_req & !mem_ready) | (state==MEM_WAIT & !mem_ready).
- `br_eff` = `branch_taken` | `branch_pending`.
- Output priority (first match wins):
  1. FAULT or `mem_stall`: all four freezes = 1, flushes = 0.
  2. `br_eff`: `flush_if_id` = `flush_id_exe` = 1, freezes = 0. Branch beats hazard because the hazarding instruction is flushed.
  3. `hazard`: `freeze_if` = 1, `flush_id_exe` = 1, other freezes = 0.
  4. Otherwise: all 0.
- Transitions:
  - RUN→MEM_WAIT on `mem_req & !mem_ready`.
  - MEM_WAIT→RUN on `mem_ready`.
  - MEM_WAIT→FAULT when `wait_cnt` reaches MEM_TIMEOUT−1 with `mem_ready`=0.
  - FAULT is left only by reset.
- `wait_cnt`: cleared on entering MEM_WAIT, incremented each MEM_WAIT cycle.
- `mem_req & mem_ready` in RUN: no stall, stays in RUN.
- `branch_pending`:
  - Set when `branch_taken`=1 while case 1 applies.
  - Cleared on the cycle case 2 drives the flush.
  - A second pulse while pending is absorbed, since the flush is idempotent.
- `mem_timeout` = (state==FAULT). Stays 1 until reset.
- Counters:
  - `cnt_clr` wins over increment.
  - Increments hold at 2^CNT_W−1.
  - Counting continues in FAULT.
- Repeated WB during a freeze is idempotent. No special handling.

## Timing
- Freeze/flush outputs are Mealy: combinational from inputs plus registered state/`branch_pending`, with zero-cycle latency.
- `state`, `branch_pending`, `wait_cnt` and counters update on the rising `clk` edge.
- While `rst`=0:
  - state=RUN, `branch_pending`=0, `wait_cnt`=0, `mem_timeout`=0, counters=0.
  - All freeze/flush outputs are forced 0.
- Release cycle (MEM_WAIT with `mem_ready`=1): no freeze from case 1, and a pending branch flushes in this same cycle.
- Reset asserted mid-MEM_WAIT or in FAULT: immediate return to RUN, pending branch discarded.
- `stall_cycles` and `flush_count` reflect a cycle's outputs from the following cycle.

## Structure
- Shared package `arm_pipe_pkg`: state encoding constants (RUN/MEM_WAIT/FAULT) and default CNT_W.
- Sub-module `sat_counter` (parameter W; inputs `inc`, `clr`; async active-low reset), instantiated twice for the counters.
- `wait_cnt` width is $clog2(MEM_TIMEOUT), kept inline.

## Test plan
- Hazard=1 for 2 cycles, no other events -> `freeze_if`=1 and `flush_id_exe`=1 for exactly 2 cycles, other freezes 0, `stall_cycles`=2.
- `mem_req`=1 with `mem_ready` low for 3 cycles then high -> all freezes 1 for 3 cycles, state goes 0→1→1→0, release cycle all freezes 0.
- `branch_taken` pulse in the 2nd cycle of a 4-cycle memory stall -> no flush during the stall, `flush_if_id`=`flush_id_exe`=1 on the release cycle only, `flush_count`=1.
- `hazard` and `branch_taken` together in RUN -> flushes 1, `freeze_if`=0.
- MEM_TIMEOUT=4, `mem_ready` held low -> FAULT after 4 MEM_WAIT cycles with `mem_timeout`=1 and freezes 1, persisting despite a later `mem_ready`. Async `rst` low clears everything to reset values.
- CNT_W=3, continuous hazard for 10 cycles -> `stall_cycles` saturates at 7. `cnt_clr` together with hazard -> 0 next cycle.
